spart_bus_ctrl: RTL and testbench

SPART_BUS_CTRL -- requirements
Module: spart_bus_ctrl

---
 rtl/spart_pkg.sv | 35 +++
 rtl/spart_tx_fifo.sv | 64 ++++++
 rtl/spart_bus_ctrl.sv | 136 +++++++++++++
 tb/tb_spart_bus_ctrl.sv | 347 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spart_pkg.sv
// Shared definitions for the SPART bus controller: FSM states, SPART register
// addresses and baud divisor constants for a 50 MHz system clock.
package spart_pkg;

  typedef enum logic [2:0] {
    INIT   = 3'd0,
    CFG_LO = 3'd1,
    CFG_HI = 3'd2,
    IDLE   = 3'd3,
    RX     = 3'd4,
    TX     = 3'd5
  } state_e;

  localparam logic [1:0] ADDR_DATA   = 2'b00;
  localparam logic [1:0] ADDR_STATUS = 2'b01;
  localparam logic [1:0] ADDR_DIV_LO = 2'b10;
  localparam logic [1:0] ADDR_DIV_HI = 2'b11;

  localparam logic [15:0] DIV_4800  = 16'd10416;
  localparam logic [15:0] DIV_9600  = 16'd5207;
  localparam logic [15:0] DIV_19200 = 16'd2603;
  localparam logic [15:0] DIV_38400 = 16'd1301;

  function automatic logic [15:0] divisor_for(input logic [1:0] sel);
    logic [15:0] div;
    case (sel)
      2'b00:   div = DIV_4800;
      2'b01:   div = DIV_9600;
      2'b10:   div = DIV_19200;
      default: div = DIV_38400;
    endcase
    return div;
  endfunction

endpackage

// File: rtl/spart_tx_fifo.sv
// Byte-wide TX FIFO with power-of-two depth; pointers wrap naturally and the
// occupancy counter carries one extra bit so it can represent a full FIFO.
module spart_tx_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  logic [7:0]               push_data_i,
  input  logic                     pop_i,
  output logic [7:0]               head_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          do_push, do_pop;

  assign full_o  = (count_q == FULL_COUNT);
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: contents are only visible through valid pointers.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/spart_bus_ctrl.sv
// Bus master for a SPART: programs the baud divisor, services received bytes
// and drains a two-requester TX FIFO onto the SPART data register.
module spart_bus_ctrl
  import spart_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [1:0]                  br_cfg,
  output logic                        iocs,
  output logic                        iorw,
  output logic [1:0]                  ioaddr,
  inout  wire  [7:0]                  databus,
  input  logic                        rda,
  input  logic                        tbr,
  input  logic                        req0_valid,
  input  logic [7:0]                  req0_data,
  output logic                        req0_ready,
  input  logic                        req1_valid,
  input  logic [7:0]                  req1_data,
  output logic                        req1_ready,
  output logic [7:0]                  rx_data,
  output logic                        rx_valid,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

  state_e      state_q, state_d;
  logic [1:0]  br_cfg_q;
  logic [7:0]  rx_data_q;
  logic        rx_valid_q;
  logic        last_q;
  logic [15:0] divisor;
  logic [7:0]  bus_out;
  logic        fifo_pop;
  logic        fifo_push;
  logic [7:0]  fifo_push_data;
  logic [7:0]  fifo_head;
  logic        fifo_full;
  logic        fifo_empty;
  logic        grant0, grant1;

  spart_tx_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_tx_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (fifo_push),
    .push_data_i (fifo_push_data),
    .pop_i       (fifo_pop),
    .head_o      (fifo_head),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .count_o     (fifo_count)
  );

  assign divisor = divisor_for(br_cfg_q);

  // last_q=1 means requester 1 was served last, so requester 0 wins a tie.
  always_comb begin
    grant0         = req0_valid && (!req1_valid || last_q);
    grant1         = req1_valid && (!req0_valid || !last_q);
    req0_ready     = rst_n && grant0 && !fifo_full;
    req1_ready     = rst_n && grant1 && !fifo_full;
    fifo_push      = (req0_valid && req0_ready) || (req1_valid && req1_ready);
    fifo_push_data = req1_ready ? req1_data : req0_data;
  end

  always_comb begin
    state_d  = state_q;
    iocs     = 1'b0;
    iorw     = 1'b1;
    ioaddr   = ADDR_DATA;
    bus_out  = 8'h00;
    fifo_pop = 1'b0;
    case (state_q)
      INIT: state_d = CFG_LO;
      CFG_LO: begin
        iocs    = 1'b1;
        iorw    = 1'b0;
        ioaddr  = ADDR_DIV_LO;
        bus_out = divisor[7:0];
        state_d = CFG_HI;
      end
      CFG_HI: begin
        iocs    = 1'b1;
        iorw    = 1'b0;
        ioaddr  = ADDR_DIV_HI;
        bus_out = divisor[15:8];
        state_d = IDLE;
      end
      IDLE: begin
        if (rda)                     state_d = RX;
        else if (tbr && !fifo_empty) state_d = TX;
      end
      RX: begin
        iocs    = 1'b1;
        iorw    = 1'b1;
        ioaddr  = ADDR_DATA;
        state_d = IDLE;
      end
      TX: begin
        iocs     = 1'b1;
        iorw     = 1'b0;
        ioaddr   = ADDR_DATA;
        bus_out  = fifo_head;
        fifo_pop = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = INIT;
    endcase
    // A baud change always wins; the current bus cycle still completes.
    if (br_cfg != br_cfg_q) state_d = CFG_LO;
  end

  assign databus  = (iocs && !iorw) ? bus_out : 8'hzz;
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= INIT;
      br_cfg_q   <= br_cfg;
      rx_data_q  <= 8'h00;
      rx_valid_q <= 1'b0;
      last_q     <= 1'b1;
    end else begin
      state_q    <= state_d;
      rx_valid_q <= (state_q == RX);
      if (state_d == CFG_LO) br_cfg_q <= br_cfg;
      if (state_q == RX) rx_data_q <= databus;
      if (fifo_push) last_q <= req1_ready;
    end
  end

endmodule

// File: tb/tb_spart_bus_ctrl.sv
// Directed and randomized checks of spart_bus_ctrl against a queue-based
// model of the FIFO, the alternating arbiter and the SPART bus protocol.
module tb_spart_bus_ctrl;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] br_cfg;
  logic       iocs, iorw;
  logic [1:0] ioaddr;
  wire  [7:0] databus;
  logic       rda, tbr;
  logic       req0_valid, req1_valid, req0_ready, req1_ready;
  logic [7:0] req0_data, req1_data;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [$clog2(DEPTH):0] fifo_count;
  logic [7:0] tbBusVal;

  int checks = 0;
  int errors = 0;

  logic [15:0] divTab [4];
  logic [7:0]  modelQ [$];
  logic        modelLast;
  logic        pendRx;
  logic [7:0]  expRx;
  logic [1:0]  prevCfg, loCfg;
  logic [7:0]  accLog [$];
  logic [7:0]  txLog [$];
  logic [9:0]  cfgLog [$];
  logic [10:0] busLog [$];
  int          rdCount = 0;

  spart_bus_ctrl #(.FIFO_DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .br_cfg     (br_cfg),
    .iocs       (iocs),
    .iorw       (iorw),
    .ioaddr     (ioaddr),
    .databus    (databus),
    .rda        (rda),
    .tbr        (tbr),
    .req0_valid (req0_valid),
    .req0_data  (req0_data),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_data  (req1_data),
    .req1_ready (req1_ready),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .fifo_count (fifo_count)
  );

  // The SPART model answers reads with tbBusVal.
  assign databus = (iocs && iorw) ? tbBusVal : 8'hzz;

  always #10 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic v0, input logic [7:0] d0, input logic v1, input logic [7:0] d1);
    @(posedge clk); #1;
    req0_valid = v0;
    req0_data  = d0;
    req1_valid = v1;
    req1_data  = d1;
  endtask

  task automatic waitDrain(input string tag);
    bit done = 1'b0;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      if (fifo_count == 0 && !iocs) done = 1'b1;
    end
    checkOutput(tag, 32'(done), 32'd1);
    repeat (2) @(posedge clk);
    #1;
  endtask

  // Reference model: FIFO as a queue, tie-break alternates on accepted pushes.
  always @(negedge clk) begin : monitor
    logic full, exp0, exp1, push0, push1;
    if (!rst_n) begin
      modelQ.delete();
      modelLast = 1'b1;
      pendRx    = 1'b0;
    end else begin
      checkOutput("fifo_count", 32'(fifo_count), 32'(modelQ.size()));
      full = (modelQ.size() >= DEPTH);
      exp0 = req0_valid && !full && (!req1_valid || modelLast);
      exp1 = req1_valid && !full && (!req0_valid || !modelLast);
      checkOutput("ready", {30'd0, req0_ready, req1_ready}, {30'd0, exp0, exp1});
      checkOutput("rx_valid", 32'(rx_valid), 32'(pendRx));
      if (pendRx) checkOutput("rx_data", 32'(rx_data), 32'(expRx));
      pendRx = 1'b0;
      if (iocs && iorw) begin
        rdCount++;
        busLog.push_back({1'b1, ioaddr, databus});
        if (ioaddr == 2'b00) begin
          pendRx = 1'b1;
          expRx  = databus;
        end
      end
      if (iocs && !iorw) begin
        busLog.push_back({1'b0, ioaddr, databus});
        case (ioaddr)
          2'b00: begin
            txLog.push_back(databus);
            checkOutput("tx_nonempty", 32'(modelQ.size() != 0), 32'd1);
            if (modelQ.size() != 0) checkOutput("tx_data", 32'(databus), 32'(modelQ.pop_front()));
          end
          2'b10: begin
            cfgLog.push_back({ioaddr, databus});
            loCfg = prevCfg;
            checkOutput("div_lo", 32'(databus), 32'(divTab[prevCfg][7:0]));
          end
          2'b11: begin
            cfgLog.push_back({ioaddr, databus});
            checkOutput("div_hi", 32'(databus), 32'(divTab[loCfg][15:8]));
          end
          default: checkOutput("write_addr", 32'(ioaddr), 32'd0);
        endcase
      end
      push0 = req0_valid && req0_ready;
      push1 = req1_valid && req1_ready;
      if (push0) begin
        modelQ.push_back(req0_data);
        accLog.push_back(req0_data);
        modelLast = 1'b0;
      end
      if (push1) begin
        modelQ.push_back(req1_data);
        accLog.push_back(req1_data);
        modelLast = 1'b1;
      end
    end
    prevCfg = br_cfg;
  end

  initial begin
    int  sent;
    int  rd0;
    bit  seen;
    divTab[0] = 16'd10416;
    divTab[1] = 16'd5207;
    divTab[2] = 16'd2603;
    divTab[3] = 16'd1301;
    br_cfg = 2'b01; rda = 1'b0; tbr = 1'b0; tbBusVal = 8'h00;
    req0_valid = 1'b1; req0_data = 8'h11; req1_valid = 1'b1; req1_data = 8'h22;
    rst_n = 1'b0;

    // Reset state, with both requesters valid to show ready stays low
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_iocs", 32'(iocs), 32'd0);
    checkOutput("rst_iorw", 32'(iorw), 32'd1);
    checkOutput("rst_ioaddr", 32'(ioaddr), 32'd0);
    checkOutput("rst_rx_valid", 32'(rx_valid), 32'd0);
    checkOutput("rst_rx_data", 32'(rx_data), 32'd0);
    checkOutput("rst_fifo_count", 32'(fifo_count), 32'd0);
    checkOutput("rst_ready", {30'd0, req0_ready, req1_ready}, 32'd0);

    // Startup configuration at 9600 baud
    @(posedge clk); #1;
    req0_valid = 1'b0; req1_valid = 1'b0; rst_n = 1'b1;
    @(negedge clk);
    checkOutput("init_bus_idle", 32'(iocs), 32'd0);
    @(negedge clk);
    checkOutput("cfg_lo_write", {20'd0, iocs, iorw, ioaddr, databus}, {20'd0, 1'b1, 1'b0, 2'b10, 8'h57});
    @(negedge clk);
    checkOutput("cfg_hi_write", {20'd0, iocs, iorw, ioaddr, databus}, {20'd0, 1'b1, 1'b0, 2'b11, 8'h14});
    @(negedge clk);
    checkOutput("cfg_done_idle", 32'(iocs), 32'd0);

    // Single receive
    rd0 = rdCount;
    @(posedge clk); #1;
    tbBusVal = 8'hA5; rda = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      if (iocs && iorw && ioaddr == 2'b00) seen = 1'b1;
    end
    checkOutput("rx_read_seen", 32'(seen), 32'd1);
    @(posedge clk); #1;
    rda = 1'b0;
    @(negedge clk);
    checkOutput("rx_pulse", {23'd0, rx_valid, rx_data}, {23'd0, 1'b1, 8'hA5});
    @(negedge clk);
    checkOutput("rx_pulse_end", {23'd0, rx_valid, rx_data}, {23'd0, 1'b0, 8'hA5});
    repeat (3) @(posedge clk); #1;
    checkOutput("rx_single_read", 32'(rdCount - rd0), 32'd1);

    // Two requesters contending, transmitter ready
    accLog.delete(); txLog.delete();
    tbr = 1'b1;
    applyStimulus(1'b1, 8'h11, 1'b1, 8'h22);
    repeat (6) @(posedge clk);
    #1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    waitDrain("arb_drain");
    checkOutput("arb_accepted_ge4", 32'(accLog.size() >= 4), 32'd1);
    checkOutput("arb_tx_count", 32'(txLog.size()), 32'(accLog.size()));
    for (int i = 0; i < 4; i++) begin
      if (i < accLog.size()) checkOutput("arb_accept_order", 32'(accLog[i]), (i % 2 == 0) ? 32'h11 : 32'h22);
      if (i < txLog.size())  checkOutput("arb_tx_order", 32'(txLog[i]), (i % 2 == 0) ? 32'h11 : 32'h22);
    end

    // Fill to full with transmitter blocked, then drain
    txLog.delete();
    tbr = 1'b0; sent = 0;
    applyStimulus(1'b1, 8'h30, 1'b0, 8'h00);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (req0_valid && req0_ready) sent++;
      applyStimulus(1'b1, 8'h30 + 8'(sent), 1'b0, 8'h00);
    end
    @(negedge clk);
    checkOutput("full_count", 32'(fifo_count), 32'd4);
    checkOutput("full_ready_low", 32'(req0_ready), 32'd0);
    checkOutput("full_accepted", 32'(sent), 32'd4);
    @(posedge clk); #1;
    tbr = 1'b1;
    for (int i = 0; i < 30 && sent < 5; i++) begin
      @(negedge clk);
      if (req0_valid && req0_ready) sent++;
      @(posedge clk); #1;
      req0_data = 8'h30 + 8'(sent);
      if (sent == 5) req0_valid = 1'b0;
    end
    req0_valid = 1'b0;
    checkOutput("fifth_accepted", 32'(sent), 32'd5);
    waitDrain("full_drain");
    checkOutput("full_tx_count", 32'(txLog.size()), 32'd5);
    for (int i = 0; i < 5 && i < txLog.size(); i++)
      checkOutput("full_tx_order", 32'(txLog[i]), 32'h30 + 32'(i));

    // Receive has priority over transmit
    tbr = 1'b0;
    applyStimulus(1'b0, 8'h00, 1'b1, 8'h77);
    applyStimulus(1'b0, 8'h00, 1'b0, 8'h00);
    busLog.delete();
    @(posedge clk); #1;
    tbBusVal = 8'h3C; rda = 1'b1; tbr = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      if (iocs && iorw) seen = 1'b1;
    end
    @(posedge clk); #1;
    rda = 1'b0;
    waitDrain("prio_drain");
    checkOutput("prio_events", 32'(busLog.size()), 32'd2);
    if (busLog.size() >= 2) begin
      checkOutput("prio_first_rx", 32'(busLog[0]), {21'd0, 1'b1, 2'b00, 8'h3C});
      checkOutput("prio_then_tx", 32'(busLog[1]), {21'd0, 1'b0, 2'b00, 8'h77});
    end

    // Baud changes: to 4800, then to 38400 with two bytes queued
    tbr = 1'b0;
    cfgLog.delete();
    @(posedge clk); #1;
    br_cfg = 2'b00;
    repeat (6) @(posedge clk);
    #1;
    checkOutput("cfg00_count", 32'(cfgLog.size()), 32'd2);
    if (cfgLog.size() >= 2) begin
      checkOutput("cfg00_lo", 32'(cfgLog[0]), {22'd0, 2'b10, 8'hB0});
      checkOutput("cfg00_hi", 32'(cfgLog[1]), {22'd0, 2'b11, 8'h28});
    end
    applyStimulus(1'b1, 8'h81, 1'b0, 8'h00);
    applyStimulus(1'b1, 8'h82, 1'b0, 8'h00);
    applyStimulus(1'b0, 8'h00, 1'b0, 8'h00);
    cfgLog.delete(); txLog.delete();
    br_cfg = 2'b11;
    repeat (5) @(posedge clk);
    @(negedge clk);
    checkOutput("cfg11_count", 32'(cfgLog.size()), 32'd2);
    if (cfgLog.size() >= 2) begin
      checkOutput("cfg11_lo", 32'(cfgLog[0]), {22'd0, 2'b10, 8'h15});
      checkOutput("cfg11_hi", 32'(cfgLog[1]), {22'd0, 2'b11, 8'h05});
    end
    checkOutput("cfg11_fifo_kept", 32'(fifo_count), 32'd2);
    @(posedge clk); #1;
    tbr = 1'b1;
    waitDrain("cfg11_drain");
    checkOutput("cfg11_tx_count", 32'(txLog.size()), 32'd2);
    if (txLog.size() >= 2) begin
      checkOutput("cfg11_tx0", 32'(txLog[0]), 32'h81);
      checkOutput("cfg11_tx1", 32'(txLog[1]), 32'h82);
    end

    // Reset in the middle of a transmit cycle
    tbr = 1'b0;
    applyStimulus(1'b1, 8'h91, 1'b0, 8'h00);
    applyStimulus(1'b1, 8'h92, 1'b0, 8'h00);
    applyStimulus(1'b0, 8'h00, 1'b0, 8'h00);
    tbr = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      if (iocs && !iorw && ioaddr == 2'b00) seen = 1'b1;
    end
    checkOutput("midrst_tx_seen", 32'(seen), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_iocs", 32'(iocs), 32'd0);
    checkOutput("midrst_fifo_count", 32'(fifo_count), 32'd0);
    @(posedge clk); #1;
    tbr = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    checkOutput("midrst_after_count", 32'(fifo_count), 32'd0);

    // Randomized traffic checked by the monitor model
    for (int c = 0; c < 800; c++) begin
      @(posedge clk); #1;
      req0_valid = 1'($urandom_range(0, 1));
      req0_data  = 8'($urandom);
      req1_valid = 1'($urandom_range(0, 1));
      req1_data  = 8'($urandom);
      rda        = ($urandom_range(0, 7) == 0);
      tbr        = 1'($urandom_range(0, 1));
      tbBusVal   = 8'($urandom);
      if ($urandom_range(0, 63) == 0) br_cfg = 2'($urandom_range(0, 3));
    end
    @(posedge clk); #1;
    req0_valid = 1'b0; req1_valid = 1'b0; rda = 1'b0; tbr = 1'b1;
    waitDrain("random_drain");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
